// File: rtl/dmem_responder_if.sv
// Load/store handshake bundle between the CPU (master) and its data memory (slave).
// Request and response each use their own valid/ready pair.
interface dmem_responder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWrData;
  logic [3:0]  ReqByteEn;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspRdData;
  logic        RspErr;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWrData, ReqByteEn, RspReady,
    input  ReqReady, RspValid, RspRdData, RspErr
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqWrData, ReqByteEn, RspReady,
    output ReqReady, RspValid, RspRdData, RspErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word-addressed data memory with programmable wait states.
// One request in flight: IDLE accepts, WAIT counts down and performs the access, RESP holds the answer.
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic           Clk,
  input logic           Rst,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  stateNxt_s;
  logic [3:0]              waitCnt_r;
  logic [3:0]              waitCntNxt_s;
  logic                    rspValid_r;
  logic                    rspValidNxt_s;
  logic                    rspErr_r;
  logic                    rspErrNxt_s;
  logic [31:0]             rspRdData_r;
  logic [31:0]             rspRdDataNxt_s;

  logic                    reqWrite_r;
  logic [31:0]             reqAddr_r;
  logic [31:0]             reqWrData_r;
  logic [3:0]              reqByteEn_r;

  logic [31:0]             mem_r [DEPTH];

  logic [31:0]             offset_s;
  logic [ADDR_WIDTH-1:0]   memIdx_s;
  logic                    accessErr_s;
  logic                    accessEdge_s;
  logic                    memWe_s;

  function automatic logic [31:0] mergeBytes(
    input logic [31:0] oldWord,
    input logic [31:0] newWord,
    input logic [3:0]  byteEn
  );
    logic [31:0] merged;
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) begin
        merged[8*i +: 8] = newWord[8*i +: 8];
      end else begin
        merged[8*i +: 8] = oldWord[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // Offset wraps at 32 bits, so anything below BASE_ADDR lands far out of range.
  assign offset_s     = reqAddr_r - BASE_ADDR;
  assign memIdx_s     = offset_s[ADDR_WIDTH+1:2];
  assign accessErr_s  = (reqAddr_r[1:0] != 2'b00) ||
                        ((offset_s >> (ADDR_WIDTH + 2)) != 32'd0);
  assign accessEdge_s = (state_r == ST_WAIT) && (waitCnt_r == 4'd0);
  assign memWe_s      = accessEdge_s && reqWrite_r && !accessErr_s && !Rst;

  assign bus.ReqReady  = (state_r == ST_IDLE);
  assign bus.RspValid  = rspValid_r;
  assign bus.RspRdData = rspRdData_r;
  assign bus.RspErr    = rspErr_r;

  // State register and registered response outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= ST_IDLE;
      waitCnt_r   <= 4'd0;
      rspValid_r  <= 1'b0;
      rspErr_r    <= 1'b0;
      rspRdData_r <= 32'd0;
    end else begin
      state_r     <= stateNxt_s;
      waitCnt_r   <= waitCntNxt_s;
      rspValid_r  <= rspValidNxt_s;
      rspErr_r    <= rspErrNxt_s;
      rspRdData_r <= rspRdDataNxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    stateNxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ReqValid) begin
          stateNxt_s = ST_WAIT;
        end else begin
          stateNxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (waitCnt_r == 4'd0) begin
          stateNxt_s = ST_RESP;
        end else begin
          stateNxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.RspReady) begin
          stateNxt_s = ST_IDLE;
        end else begin
          stateNxt_s = ST_RESP;
        end
      end
      default: stateNxt_s = ST_IDLE;
    endcase
  end

  // Counter and response next values; RspRdData deliberately survives the handshake
  always_comb begin
    waitCntNxt_s   = waitCnt_r;
    rspValidNxt_s  = rspValid_r;
    rspErrNxt_s    = rspErr_r;
    rspRdDataNxt_s = rspRdData_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.ReqValid) begin
          waitCntNxt_s = 4'(WAIT_CYCLES);
        end else begin
          waitCntNxt_s = waitCnt_r;
        end
      end
      ST_WAIT: begin
        if (waitCnt_r != 4'd0) begin
          waitCntNxt_s = waitCnt_r - 4'd1;
        end else begin
          rspValidNxt_s = 1'b1;
          rspErrNxt_s   = accessErr_s;
          if (accessErr_s || reqWrite_r) begin
            rspRdDataNxt_s = 32'd0;
          end else begin
            rspRdDataNxt_s = mem_r[memIdx_s];
          end
        end
      end
      ST_RESP: begin
        if (bus.RspReady) begin
          rspValidNxt_s = 1'b0;
          rspErrNxt_s   = 1'b0;
        end else begin
          rspValidNxt_s = rspValid_r;
          rspErrNxt_s   = rspErr_r;
        end
      end
      default: begin
        waitCntNxt_s  = 4'd0;
        rspValidNxt_s = 1'b0;
        rspErrNxt_s   = 1'b0;
      end
    endcase
  end

  // Request capture at the accept edge; later input changes are ignored
  always_ff @(posedge Clk) begin
    if (!Rst && (state_r == ST_IDLE) && bus.ReqValid) begin
      reqWrite_r  <= bus.ReqWrite;
      reqAddr_r   <= bus.ReqAddr;
      reqWrData_r <= bus.ReqWrData;
      reqByteEn_r <= bus.ReqByteEn;
    end
  end

  // Storage array, not reset so contents persist through Rst
  always_ff @(posedge Clk) begin
    if (memWe_s) begin
      mem_r[memIdx_s] <= mergeBytes(mem_r[memIdx_s], reqWrData_r, reqByteEn_r);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES=2, ADDR_WIDTH=8, BASE_ADDR=0.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dmem_responder;

  logic        Clk = 1'b0;
  logic        Rst;
  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] rdData;
  logic        rdErr;
  int          lat;

  dmem_responder_if bus();

  dmem_responder #(
    .ADDR_WIDTH (8),
    .WAIT_CYCLES(2),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge, then scramble the inputs to prove they were latched
  task automatic startReq(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be);
    @(negedge Clk);
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = wr;
    bus.ReqAddr   = addr;
    bus.ReqWrData = data;
    bus.ReqByteEn = be;
    bus.RspReady  = 1'b0;
    @(negedge Clk);
    check("accept_ready_low", {31'd0, bus.ReqReady}, 32'd0);
    bus.ReqValid  = 1'b0;
    bus.ReqWrite  = ~wr;
    bus.ReqAddr   = ~addr;
    bus.ReqWrData = ~data;
    bus.ReqByteEn = ~be;
  endtask

  task automatic waitRsp(output int latency);
    latency = 0;
    while (bus.RspValid !== 1'b1 && latency < 20) begin
      @(negedge Clk);
      latency++;
    end
  endtask

  task automatic finishRsp(input string tag);
    bus.RspReady = 1'b1;
    @(negedge Clk);
    bus.RspReady = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.RspValid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, bus.ReqReady}, 32'd1);
  endtask

  task automatic doReq(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input string tag);
    startReq(wr, addr, data, be);
    waitRsp(lat);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    rdData = bus.RspRdData;
    rdErr  = bus.RspErr;
    finishRsp(tag);
  endtask

  initial begin
    Rst           = 1'b1;
    bus.ReqValid  = 1'b0;
    bus.ReqWrite  = 1'b0;
    bus.ReqAddr   = 32'd0;
    bus.ReqWrData = 32'd0;
    bus.ReqByteEn = 4'd0;
    bus.RspReady  = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    check("rst_reqready", {31'd0, bus.ReqReady}, 32'd1);
    check("rst_rspvalid", {31'd0, bus.RspValid}, 32'd0);
    check("rst_rddata",   bus.RspRdData,        32'd0);
    check("rst_err",      {31'd0, bus.RspErr},   32'd0);

    // Full-word store then load
    doReq(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "st_full");
    check("st_full_err",  {31'd0, rdErr}, 32'd0);
    check("st_full_data", rdData,         32'd0);
    doReq(1'b0, 32'h10, 32'h0, 4'h0, "ld_full");
    check("ld_full_err",  {31'd0, rdErr}, 32'd0);
    check("ld_full_data", rdData,         32'hDEAD_BEEF);

    // Partial store merges bytes 0 and 2
    doReq(1'b1, 32'h10, 32'h1122_3344, 4'hF, "st_seed");
    doReq(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, "st_part");
    check("st_part_err", {31'd0, rdErr}, 32'd0);
    doReq(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, "st_none");
    check("st_none_err", {31'd0, rdErr}, 32'd0);
    doReq(1'b0, 32'h10, 32'h0, 4'h0, "ld_part");
    check("ld_part_data", rdData, 32'h11BB_33DD);

    // Misaligned load
    doReq(1'b0, 32'h13, 32'h0, 4'hF, "ld_misal");
    check("ld_misal_err",  {31'd0, rdErr}, 32'd1);
    check("ld_misal_data", rdData,         32'd0);

    // Out-of-range store must not alias onto word 0
    doReq(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, "st_w0");
    doReq(1'b1, 32'h400, 32'h1234_5678, 4'hF, "st_oor");
    check("st_oor_err", {31'd0, rdErr}, 32'd1);
    doReq(1'b0, 32'h0, 32'h0, 4'h0, "ld_w0");
    check("ld_w0_err",  {31'd0, rdErr}, 32'd0);
    check("ld_w0_data", rdData,         32'hCAFE_F00D);

    // Backpressure: response held while a competing request is ignored
    startReq(1'b0, 32'h10, 32'h0, 4'h0);
    waitRsp(lat);
    check("bp_latency", 32'(lat), 32'd3);
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = 1'b1;
    bus.ReqAddr   = 32'h0;
    bus.ReqWrData = 32'h0BAD_0BAD;
    bus.ReqByteEn = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("bp_valid", {31'd0, bus.RspValid}, 32'd1);
      check("bp_data",  bus.RspRdData,        32'h11BB_33DD);
      check("bp_err",   {31'd0, bus.RspErr},   32'd0);
      check("bp_ready", {31'd0, bus.ReqReady}, 32'd0);
    end
    bus.ReqValid = 1'b0;
    finishRsp("bp");
    check("bp_data_kept", bus.RspRdData, 32'h11BB_33DD);
    doReq(1'b0, 32'h0, 32'h0, 4'h0, "ld_w0_again");
    check("ld_w0_again_data", rdData, 32'hCAFE_F00D);

    // Reset landing on the access edge of a store aborts it
    doReq(1'b1, 32'h20, 32'h0000_0055, 4'hF, "st_55");
    startReq(1'b1, 32'h20, 32'h0, 4'hF);
    @(negedge Clk);
    @(negedge Clk);
    check("abort_pre_valid", {31'd0, bus.RspValid}, 32'd0);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_reqready", {31'd0, bus.ReqReady}, 32'd1);
    check("abort_rspvalid", {31'd0, bus.RspValid}, 32'd0);
    check("abort_rddata",   bus.RspRdData,        32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("abort_quiet", {31'd0, bus.RspValid}, 32'd0);
    end
    doReq(1'b0, 32'h20, 32'h0, 4'h0, "ld_55");
    check("ld_55_data", rdData, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder, the slave end of the CPU's load/store interface. It accepts one word-addressed read or write request through a valid/ready handshake and inserts a programmable number of wait states. It then returns read data or a write acknowledgement through a second valid/ready handshake. It replaces the zero-latency data memory when the team moves the CPU to a stall-capable core.

Parameters:
ADDR_WIDTH, 8, word-address bits; array depth = 2**ADDR_WIDTH 32-bit words
WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15)
BASE_ADDR, 32'h00000000, byte address of word 0

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  synchronous active-high reset
ReqValid  in  1  request present
ReqReady  out  1  responder can accept a request
ReqWrite  in  1  1 = store, 0 = load
ReqAddr  in  32  byte address
ReqWrData  in  32  store data
ReqByteEn  in  4  store byte enables; bit i selects bits [8i+7:8i]
RspValid  out  1  response present
RspReady  in  1  requester accepts response
RspRdData  out  32  load data
RspErr  out  1  request was misaligned or out of range

Behaviour:
- Reset and handshake rules:
  - Reset and handshake rules:
  - Synchronous reset (Rst=1 at an edge) forces state=IDLE, RspValid=0, RspRdData=0, RspErr=0 and wait counter=0.
  - ReqReady=1 only in IDLE, so it reads 1 after reset.
  - The memory array is not reset; its contents are preserved across Rst.
  - ReqReady is a combinational decode of state; all other outputs are registered.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with ReqValid=1, latch ReqWrite/ReqAddr/ReqWrData/ReqByteEn.
  - Load counter=WAIT_CYCLES and go to WAIT.
- WAIT:
  - If counter!=0, decrement and stay.
  - If counter==0, perform the access at this edge: set RspValid=1 and go to RESP.
  - Latency: RspValid rises WAIT_CYCLES+1 edges after the accept edge.
- Access: word index = (addr - BASE_ADDR) >> 2.
  - Error if addr[1:0]!=0, or (addr - BASE_ADDR) >= 4*2**ADDR_WIDTH. The subtraction is a 32-bit unsigned wrap, so addresses below BASE_ADDR are out of range.
  - On error: no array write, RspRdData=0, RspErr=1, same latency as a good access.
  - Load: RspRdData = mem[index]; ReqByteEn is ignored and the full word is returned.
  - Store: for each i with byte-enable bit 1, update byte i of mem[index]; other bytes are unchanged. RspRdData=0, RspErr=0. A store with ByteEn=4'b0000 is legal: no change, normal response.
- RESP:
  - RspValid, RspRdData and RspErr are held stable while RspReady=0.
  - On an edge with RspReady=1: RspValid=0, RspErr=0, go to IDLE. RspRdData retains its value.
  - No new request is accepted in the same edge; minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Read-after-write: a load issued after a store response completes returns the stored bytes.
- Reset mid-operation:
  - Rst wins over every other event at the same edge.
  - Rst during WAIT, including the access edge, aborts the request: no array write occurs.
  - Rst during RESP drops RspValid and discards the response.
- Signals outside IDLE: ReqValid is ignored in WAIT/RESP. Latched request fields are unaffected by input changes after acceptance.

Test Plan:
- Reset then idle: after Rst=1 for 1 edge -> ReqReady=1, RspValid=0, RspRdData=0, RspErr=0.
- Full-word store/load, WAIT_CYCLES=2:
  - Store 32'hDEADBEEF to 32'h10 with ByteEn=4'hF -> RspValid rises exactly 3 edges after accept, RspErr=0.
  - Load from 32'h10 -> RspRdData=32'hDEADBEEF.
- Partial store: mem[4]=32'h11223344, then store 32'hAABBCCDD with ByteEn=4'b0101 -> subsequent load of 32'h10 returns 32'h11BB33DD.
- Errors:
  - Load 32'h13 -> RspErr=1, RspRdData=0.
  - Store to 32'h400 (ADDR_WIDTH=8) -> RspErr=1 and word 0 unchanged.
- Backpressure: hold RspReady=0 for 5 cycles after RspValid -> outputs stable and ReqReady=0 throughout; RspReady=1 -> RspValid=0 next edge, ReqReady=1.
- Reset mid-store: assert Rst on the access edge of a store of 32'h0 to a word holding 32'h55 -> state IDLE, RspValid never rises, word still 32'h55.
